// File: rtl/fp_fflag_commit_if.sv
// Commit-request handshake between the in-order commit stage and the fflag buffer.
interface fp_fflag_commit_if #(
    parameter int TAGW = 3,
    parameter int XLEN = 64
);
    logic            cmt_valid;
    logic            cmt_ready;
    logic [TAGW-1:0] cmt_itag;
    logic            cmt_fpop;
    logic            cmt_csren;
    logic [11:0]     cmt_csrindex;
    logic [XLEN-1:0] cmt_csrdata;

    modport master (
        output cmt_valid, cmt_itag, cmt_fpop,
        output cmt_csren, cmt_csrindex, cmt_csrdata,
        input  cmt_ready
    );

    modport slave (
        input  cmt_valid, cmt_itag, cmt_fpop,
        input  cmt_csren, cmt_csrindex, cmt_csrdata,
        output cmt_ready
    );
endinterface

// File: rtl/fp_fflag_commit.sv
// Per-tag FP exception-flag buffer; emits a registered commit beat to the FP CSR block.
// Optional FFLAG_WB_BYPASS_EN lets a same-cycle writeback satisfy a commit on its tag.
module fp_fflag_commit #(
    parameter int DEPTH = 8,
    parameter int TAGW  = $clog2(DEPTH),
    parameter int XLEN  = 64
) (
    input  logic                clk_i,
    input  logic                arst_i,
    input  logic                alloc_valid,
    input  logic [TAGW-1:0]     alloc_itag,
    input  logic                wb_valid,
    input  logic [TAGW-1:0]     wb_itag,
    input  logic [4:0]          wb_fflag,
    fp_fflag_commit_if.slave    cmt,
    input  logic                flush,
    output logic                valid,
    output logic                csren,
    output logic [11:0]         csrindex,
    output logic [XLEN-1:0]     csrdata,
    output logic                fflagen,
    output logic [4:0]          fflag
);
    logic [DEPTH-1:0]      r_done;
    logic [DEPTH-1:0][4:0] r_flag;
    logic [DEPTH-1:0]      w_done_nxt;
    logic [DEPTH-1:0][4:0] w_flag_nxt;
    logic                  w_byp;
    logic                  w_acc;
    logic [4:0]            w_cflag;

`ifdef FFLAG_WB_BYPASS_EN
    assign w_byp = wb_valid && (wb_itag == cmt.cmt_itag);
`else
    assign w_byp = 1'b0;
`endif

    assign cmt.cmt_ready = !cmt.cmt_fpop || r_done[cmt.cmt_itag] || w_byp;
    assign w_acc         = cmt.cmt_valid && cmt.cmt_ready;
    assign w_cflag       = w_byp ? wb_fflag : r_flag[cmt.cmt_itag];

    // Priority low to high: writeback, commit clear, alloc; flush overrides all.
    always_comb begin
        w_done_nxt = r_done;
        w_flag_nxt = r_flag;
        if (flush) begin
            w_done_nxt = '0;
        end else begin
            if (wb_valid) begin
                w_done_nxt[wb_itag] = 1'b1;
                w_flag_nxt[wb_itag] = wb_fflag;
            end
            if (w_acc) begin
                w_done_nxt[cmt.cmt_itag] = 1'b0;
            end
            if (alloc_valid) begin
                w_done_nxt[alloc_itag] = 1'b0;
                w_flag_nxt[alloc_itag] = 5'd0;
            end
        end
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            r_done <= '0;
            r_flag <= '0;
        end else begin
            r_done <= w_done_nxt;
            r_flag <= w_flag_nxt;
        end
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            valid    <= 1'b0;
            csren    <= 1'b0;
            csrindex <= '0;
            csrdata  <= '0;
            fflagen  <= 1'b0;
            fflag    <= '0;
        end else if (w_acc) begin
            valid    <= 1'b1;
            csren    <= cmt.cmt_csren;
            csrindex <= cmt.cmt_csrindex;
            csrdata  <= cmt.cmt_csrdata;
            fflagen  <= cmt.cmt_fpop;
            fflag    <= cmt.cmt_fpop ? w_cflag : 5'd0;
        end else begin
            valid    <= 1'b0;
            csren    <= 1'b0;
            csrindex <= '0;
            csrdata  <= '0;
            fflagen  <= 1'b0;
            fflag    <= '0;
        end
    end
endmodule

// File: tb/tb_fp_fflag_commit.sv
// Directed bench for fp_fflag_commit with immediate-assertion checks.
module tb_fp_fflag_commit;
    localparam int DEPTH = 8;
    localparam int TAGW  = 3;
    localparam int XLEN  = 64;

    logic            clk_i = 1'b0;
    logic            arst_i = 1'b0;
    logic            alloc_valid = 1'b0;
    logic [TAGW-1:0] alloc_itag = '0;
    logic            wb_valid = 1'b0;
    logic [TAGW-1:0] wb_itag = '0;
    logic [4:0]      wb_fflag = '0;
    logic            flush = 1'b0;
    logic            valid, csren, fflagen;
    logic [11:0]     csrindex;
    logic [XLEN-1:0] csrdata;
    logic [4:0]      fflag;

    int n_asrt = 0;
    int n_fail = 0;

    fp_fflag_commit_if #(.TAGW(TAGW), .XLEN(XLEN)) cif ();

    fp_fflag_commit #(.DEPTH(DEPTH), .TAGW(TAGW), .XLEN(XLEN)) dut (
        .clk_i       (clk_i),
        .arst_i      (arst_i),
        .alloc_valid (alloc_valid),
        .alloc_itag  (alloc_itag),
        .wb_valid    (wb_valid),
        .wb_itag     (wb_itag),
        .wb_fflag    (wb_fflag),
        .cmt         (cif.slave),
        .flush       (flush),
        .valid       (valid),
        .csren       (csren),
        .csrindex    (csrindex),
        .csrdata     (csrdata),
        .fflagen     (fflagen),
        .fflag       (fflag)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic cmt_set(input logic v, input logic [TAGW-1:0] t,
                           input logic fp);
        cif.cmt_valid = v;
        cif.cmt_itag  = t;
        cif.cmt_fpop  = fp;
    endtask

    task automatic chk_beat(input string tag, input logic v,
                            input logic fe, input logic [4:0] f);
        chk({tag, ".valid"}, 64'(valid), 64'(v));
        chk({tag, ".fflagen"}, 64'(fflagen), 64'(fe));
        chk({tag, ".fflag"}, 64'(fflag), 64'(f));
    endtask

    initial begin
        cif.cmt_valid    = 1'b0;
        cif.cmt_itag     = '0;
        cif.cmt_fpop     = 1'b0;
        cif.cmt_csren    = 1'b0;
        cif.cmt_csrindex = '0;
        cif.cmt_csrdata  = '0;

        // Asynchronous reset before any clock edge
        #2 arst_i = 1'b1;
        #1;
        chk_beat("rst", 1'b0, 1'b0, 5'd0);
        chk("rst.csren", 64'(csren), 64'd0);
        chk("rst.csrdata", csrdata, 64'd0);
        cmt_set(1'b0, 3'd3, 1'b1);
        #1 chk("rst.rdy3", 64'(cif.cmt_ready), 64'd0);
        cmt_set(1'b0, 3'd7, 1'b1);
        #1 chk("rst.rdy7", 64'(cif.cmt_ready), 64'd0);
        cmt_set(1'b0, 3'd0, 1'b0);
        @(negedge clk_i);
        arst_i = 1'b0;

        // alloc 3, wb 3, commit 3
        alloc_valid = 1'b1; alloc_itag = 3'd3;
        tick();
        alloc_valid = 1'b0;
        wb_valid = 1'b1; wb_itag = 3'd3; wb_fflag = 5'b00001;
        tick();
        wb_valid = 1'b0;
        cmt_set(1'b1, 3'd3, 1'b1);
        #1 chk("t3.rdy", 64'(cif.cmt_ready), 64'd1);
        tick();
        chk_beat("t3.beat", 1'b1, 1'b1, 5'b00001);
        #1 chk("t3.rdy2", 64'(cif.cmt_ready), 64'd0);
        tick();
        chk_beat("t3.stall", 1'b0, 1'b0, 5'd0);

        // tag 2 without writeback stalls, then writeback releases it
        cmt_set(1'b1, 3'd2, 1'b1);
        #1 chk("t2.rdy0", 64'(cif.cmt_ready), 64'd0);
        tick();
        chk_beat("t2.nobeat", 1'b0, 1'b0, 5'd0);
        cmt_set(1'b0, 3'd2, 1'b1);
        wb_valid = 1'b1; wb_itag = 3'd2; wb_fflag = 5'b10000;
        tick();
        wb_valid = 1'b0;
        cmt_set(1'b1, 3'd2, 1'b1);
        #1 chk("t2.rdy1", 64'(cif.cmt_ready), 64'd1);
        tick();
        chk_beat("t2.beat", 1'b1, 1'b1, 5'b10000);

        // non-fp CSR write
        cmt_set(1'b1, 3'd0, 1'b0);
        cif.cmt_csren = 1'b1;
        cif.cmt_csrindex = 12'h003;
        cif.cmt_csrdata = 64'hE1;
        #1 chk("csr.rdy", 64'(cif.cmt_ready), 64'd1);
        tick();
        chk_beat("csr.beat", 1'b1, 1'b0, 5'd0);
        chk("csr.csren", 64'(csren), 64'd1);
        chk("csr.idx", 64'(csrindex), 64'h003);
        chk("csr.data", csrdata, 64'hE1);
        cmt_set(1'b0, 3'd0, 1'b0);
        cif.cmt_csren = 1'b0;
        cif.cmt_csrindex = '0;
        cif.cmt_csrdata = '0;
        tick();
        chk_beat("csr.idle", 1'b0, 1'b0, 5'd0);
        chk("csr.idle.data", csrdata, 64'd0);

        // flush with simultaneous commit of tag 0
        wb_valid = 1'b1; wb_itag = 3'd0; wb_fflag = 5'b00100;
        tick();
        wb_itag = 3'd1; wb_fflag = 5'b00010;
        tick();
        wb_valid = 1'b0;
        flush = 1'b1;
        cmt_set(1'b1, 3'd0, 1'b1);
        #1 chk("fl.rdy0", 64'(cif.cmt_ready), 64'd1);
        tick();
        flush = 1'b0;
        chk_beat("fl.beat0", 1'b1, 1'b1, 5'b00100);
        cmt_set(1'b1, 3'd1, 1'b1);
        #1 chk("fl.rdy1", 64'(cif.cmt_ready), 64'd0);
        tick();
        chk_beat("fl.nobeat1", 1'b0, 1'b0, 5'd0);
        cmt_set(1'b0, 3'd0, 1'b0);

        // alloc/wb ordering and commit against a slot being allocated
        alloc_valid = 1'b1; alloc_itag = 3'd6;
        wb_valid = 1'b1; wb_itag = 3'd7; wb_fflag = 5'b00011;
        tick();
        wb_itag = 3'd6; wb_fflag = 5'b11111;
        tick();
        alloc_valid = 1'b0; wb_valid = 1'b0;
        cmt_set(1'b0, 3'd6, 1'b1);
        #1 chk("aw.rdy6", 64'(cif.cmt_ready), 64'd0);
        alloc_valid = 1'b1; alloc_itag = 3'd7;
        cmt_set(1'b1, 3'd7, 1'b1);
        #1 chk("aw.rdy7", 64'(cif.cmt_ready), 64'd1);
        tick();
        alloc_valid = 1'b0;
        chk_beat("aw.beat7", 1'b1, 1'b1, 5'b00011);
        cmt_set(1'b0, 3'd7, 1'b1);
        #1 chk("aw.rdy7b", 64'(cif.cmt_ready), 64'd0);

        // writeback in the flush cycle is discarded
        flush = 1'b1;
        wb_valid = 1'b1; wb_itag = 3'd4; wb_fflag = 5'b00001;
        tick();
        flush = 1'b0; wb_valid = 1'b0;
        cmt_set(1'b0, 3'd4, 1'b1);
        #1 chk("fl.rdy4", 64'(cif.cmt_ready), 64'd0);

        // same-cycle writeback and commit on tag 5
        cmt_set(1'b1, 3'd5, 1'b1);
        wb_valid = 1'b1; wb_itag = 3'd5; wb_fflag = 5'b01000;
`ifdef FFLAG_WB_BYPASS_EN
        #1 chk("byp.rdy", 64'(cif.cmt_ready), 64'd1);
        tick();
        wb_valid = 1'b0;
        chk_beat("byp.beat", 1'b1, 1'b1, 5'b01000);
        cmt_set(1'b0, 3'd5, 1'b1);
        #1 chk("byp.done", 64'(cif.cmt_ready), 64'd0);
`else
        #1 chk("byp.rdy", 64'(cif.cmt_ready), 64'd0);
        tick();
        wb_valid = 1'b0;
        chk_beat("byp.nobeat", 1'b0, 1'b0, 5'd0);
        #1 chk("byp.rdy1", 64'(cif.cmt_ready), 64'd1);
        tick();
        chk_beat("byp.beat", 1'b1, 1'b1, 5'b01000);
`endif
        cmt_set(1'b0, 3'd0, 1'b0);

        // reset mid-stream drops the in-flight beat
        wb_valid = 1'b1; wb_itag = 3'd2; wb_fflag = 5'b00110;
        tick();
        wb_valid = 1'b0;
        cmt_set(1'b1, 3'd0, 1'b0);
        tick();
        cmt_set(1'b0, 3'd2, 1'b1);
        chk("mr.pre", 64'(valid), 64'd1);
        #2 arst_i = 1'b1;
        #1;
        chk_beat("mr.beat", 1'b0, 1'b0, 5'd0);
        chk("mr.rdy2", 64'(cif.cmt_ready), 64'd0);
        #1 arst_i = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_asrt, n_fail);
        $finish;
    end
endmodule
